// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the handshaked sequential ALU: default widths,
// opcode encodings and FSM state encodings.
// The ADD/SUB/AND/XOR codes keep the values used by the combinational alu;
// the remaining codes are new and unique.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   localparam int WORD = 32;  // default operand/result width
   localparam int OP_W = 4;   // default opcode width

   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_XOR  = 4'h3,
      ALU_OR   = 4'h4,
      ALU_SLL  = 4'h5,
      ALU_SRL  = 4'h6,
      ALU_SRA  = 4'h7,
      ALU_SLT  = 4'h8,
      ALU_SLTU = 4'h9,
      ALU_MUL  = 4'hA
   } alu_op_e;

   typedef enum logic [1:0] {
      ALUS_IDLE = 2'd0,
      ALUS_BUSY = 2'd1,
      ALUS_DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Operation channel (i_valid/o_ready + operands) and result channel
// (o_valid/i_ready + result and flags) of alu_seq.
//   master : issue/writeback side, drives i_* and observes o_*
//   slave  : the ALU, drives o_* and observes i_*
// Signal names carry the direction as seen from the ALU.
// -----------------------------------------------------------------------------
interface alu_seq_if #(
   parameter int WIDTH    = alu_seq_pkg::WORD,
   parameter int OP_WIDTH = alu_seq_pkg::OP_W
) ();

   logic                i_valid;
   logic                o_ready;
   logic [WIDTH-1:0]    i_a;
   logic [WIDTH-1:0]    i_b;
   logic [OP_WIDTH-1:0] i_opcode;
   logic                o_valid;
   logic                i_ready;
   logic [WIDTH-1:0]    o_result;
   logic                o_zero;
   logic                o_cf;
   logic                o_of;

   modport master (
      output i_valid, i_a, i_b, i_opcode, i_ready,
      input  o_ready, o_valid, o_result, o_zero, o_cf, o_of
   );

   modport slave (
      input  i_valid, i_a, i_b, i_opcode, i_ready,
      output o_ready, o_valid, o_result, o_zero, o_cf, o_of
   );

endinterface

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Unsigned shift-add multiplier, one multiplier bit per clock.
//   i_clk, i_rst : clock, synchronous active-high reset (aborts a multiply)
//   i_start      : load operands and begin; ignored inputs otherwise
//   i_a, i_b     : multiplicand, multiplier
//   o_done       : one-cycle pulse, o_prod is final while it is high
//   o_prod       : full 2*WIDTH product
// Timing: start on edge 0, iterations on edges 1..WIDTH, o_done high in the
// cycle after edge WIDTH.
// -----------------------------------------------------------------------------
module alu_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_prod
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               done_q;

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (i_start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, i_a};
            mplier_q <= i_b;
            cnt_q    <= CW'(WIDTH);
         end else if (cnt_q != '0) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
            // Last iteration: product is complete after this edge.
            done_q   <= (cnt_q == CW'(1));
         end
      end
   end

   assign o_done = done_q;
   assign o_prod = acc_q;

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Handshaked ALU between issue and writeback. One operation per transfer on
// the input channel; registered result plus zero/carry/overflow flags on the
// output channel. Single-cycle ops have latency 1 and throughput 1/clock;
// MUL uses alu_mul_seq and has latency WIDTH+1.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : alu_seq_if slave (operation and result channels)
// -----------------------------------------------------------------------------
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH    = WORD,
   parameter int OP_WIDTH = OP_W
) (
   input  logic      i_clk,
   input  logic      i_rst,
   alu_seq_if.slave  bus
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_e         state_q, state_d;
   logic               accept, is_mul;
   logic               load_alu, load_mul, mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_cf, alu_of;
   logic [WIDTH:0]     sum, diff, sll_ext, srl_ext;
   logic signed [WIDTH:0] sra_ext;
   logic [SHW-1:0]     sh;

   logic [WIDTH-1:0]   result_q;
   logic               zero_q, cf_q, of_q;

   // Ready depends on state and i_ready only, never on i_valid.
   assign bus.o_ready = !i_rst && ((state_q == ALUS_IDLE) ||
                                   (state_q == ALUS_DONE && bus.i_ready));
   assign bus.o_valid = (state_q == ALUS_DONE);
   assign accept      = bus.i_valid && bus.o_ready;
   assign is_mul      = (bus.i_opcode == OP_WIDTH'(ALU_MUL));

   // Single-cycle datapath. The extra bit on the shift vectors catches the
   // last bit shifted out, which is 0 for a zero shift amount.
   always_comb begin
      sh      = bus.i_b[SHW-1:0];
      sum     = {1'b0, bus.i_a} + {1'b0, bus.i_b};
      diff    = {1'b0, bus.i_a} - {1'b0, bus.i_b};
      sll_ext = {1'b0, bus.i_a} << sh;
      srl_ext = {bus.i_a, 1'b0} >> sh;
      sra_ext = $signed({bus.i_a, 1'b0}) >>> sh;
      // NOTE: every always_comb output gets a default first so no path
      // through the case can leave it unassigned and infer a latch.
      alu_res = '0;
      alu_cf  = 1'b0;
      alu_of  = 1'b0;
      case (bus.i_opcode)
         OP_WIDTH'(ALU_ADD): begin
            alu_res = sum[WIDTH-1:0];
            alu_cf  = sum[WIDTH];
            alu_of  = (bus.i_a[WIDTH-1] == bus.i_b[WIDTH-1]) &&
                      (sum[WIDTH-1] != bus.i_a[WIDTH-1]);
         end
         OP_WIDTH'(ALU_SUB): begin
            alu_res = diff[WIDTH-1:0];
            alu_cf  = diff[WIDTH];  // borrow
            alu_of  = (bus.i_a[WIDTH-1] != bus.i_b[WIDTH-1]) &&
                      (diff[WIDTH-1] != bus.i_a[WIDTH-1]);
         end
         OP_WIDTH'(ALU_AND): alu_res = bus.i_a & bus.i_b;
         OP_WIDTH'(ALU_OR):  alu_res = bus.i_a | bus.i_b;
         OP_WIDTH'(ALU_XOR): alu_res = bus.i_a ^ bus.i_b;
         OP_WIDTH'(ALU_SLL): begin
            alu_res = sll_ext[WIDTH-1:0];
            alu_cf  = sll_ext[WIDTH];
         end
         OP_WIDTH'(ALU_SRL): begin
            alu_res = srl_ext[WIDTH:1];
            alu_cf  = srl_ext[0];
         end
         OP_WIDTH'(ALU_SRA): begin
            alu_res = sra_ext[WIDTH:1];
            alu_cf  = sra_ext[0];
         end
         OP_WIDTH'(ALU_SLT):
            alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.i_a) < $signed(bus.i_b)};
         OP_WIDTH'(ALU_SLTU):
            alu_res = {{(WIDTH-1){1'b0}}, bus.i_a < bus.i_b};
         default: ;  // unknown opcode (and MUL, handled below): zero result
      endcase
   end

   // Next-state / control. IDLE and DONE share the accept path, which is what
   // lets a retiring result and a new op swap on the same edge.
   always_comb begin
      state_d   = state_q;
      load_alu  = 1'b0;
      load_mul  = 1'b0;
      mul_start = 1'b0;
      case (state_q)
         ALUS_IDLE, ALUS_DONE: begin
            if (accept) begin
               if (is_mul) begin
                  mul_start = 1'b1;
                  state_d   = ALUS_BUSY;
               end else begin
                  load_alu  = 1'b1;
                  state_d   = ALUS_DONE;
               end
            end else if (state_q == ALUS_DONE && bus.i_ready) begin
               state_d = ALUS_IDLE;
            end
         end
         ALUS_BUSY: begin
            if (mul_done) begin
               load_mul = 1'b1;
               state_d  = ALUS_DONE;
            end
         end
         default: state_d = ALUS_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ALUS_IDLE;
      else       state_q <= state_d;
   end

   // Output register; held whenever neither load is active.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         cf_q     <= 1'b0;
         of_q     <= 1'b0;
      end else if (load_alu) begin
         result_q <= alu_res;
         zero_q   <= (alu_res == '0);
         cf_q     <= alu_cf;
         of_q     <= alu_of;
      end else if (load_mul) begin
         result_q <= mul_prod[WIDTH-1:0];
         zero_q   <= (mul_prod[WIDTH-1:0] == '0);
         cf_q     <= |mul_prod[2*WIDTH-1:WIDTH];
         of_q     <= 1'b0;
      end
   end

   assign bus.o_result = result_q;
   assign bus.o_zero   = zero_q;
   assign bus.o_cf     = cf_q;
   assign bus.o_of     = of_q;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (mul_start),
      .i_a     (bus.i_a),
      .i_b     (bus.i_b),
      .o_done  (mul_done),
      .o_prod  (mul_prod)
   );

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq: reset, ADD/SUB flags, back-to-back single-cycle
// ops, multiply latency, back-pressure, reset during a multiply, compares and
// an unknown opcode. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   alu_seq_if #(.WIDTH(32), .OP_WIDTH(4)) bus ();

   alu_seq #(.WIDTH(32), .OP_WIDTH(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic v);
      bus.i_opcode = op;
      bus.i_a      = a;
      bus.i_b      = b;
      bus.i_valid  = v;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_ready = 1'b1;
      drive(ALU_ADD, 32'h0, 32'h0, 1'b1);
      cyc();
      cyc();
      total++;
      if (bus.o_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready_low got=%b want=0", bus.o_ready);
      end
      rst = 1'b0;
      bus.i_valid = 1'b0;
      #1;
      total++;
      if ({bus.o_ready, bus.o_valid, bus.o_zero, bus.o_cf, bus.o_of} !== 5'b10000) begin
         bad++; $display("FAIL reset_ctrl_flags got=%b want=10000",
                         {bus.o_ready, bus.o_valid, bus.o_zero, bus.o_cf, bus.o_of});
      end
      total++;
      if (bus.o_result !== 32'h0) begin
         bad++; $display("FAIL reset_result got=%h want=00000000", bus.o_result);
      end
   endtask

   task automatic test_add_sub();
      // ADD with carry-out to zero
      drive(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
      cyc();
      bus.i_valid = 1'b0;
      total++;
      if ({bus.o_valid, bus.o_zero, bus.o_cf, bus.o_of} !== 4'b1110 || bus.o_result !== 32'h0) begin
         bad++; $display("FAIL add_carry got v/z/c/o=%b res=%h want 1110 res=00000000",
                         {bus.o_valid, bus.o_zero, bus.o_cf, bus.o_of}, bus.o_result);
      end
      cyc();
      total++;
      if (bus.o_valid !== 1'b0) begin
         bad++; $display("FAIL add_valid_one_cycle got=%b want=0", bus.o_valid);
      end
      // Three SUBs back to back
      drive(ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      cyc();
      total++;
      if ({bus.o_valid, bus.o_zero, bus.o_cf, bus.o_of} !== 4'b1011 || bus.o_result !== 32'h8000_0000) begin
         bad++; $display("FAIL sub_overflow got v/z/c/o=%b res=%h want 1011 res=80000000",
                         {bus.o_valid, bus.o_zero, bus.o_cf, bus.o_of}, bus.o_result);
      end
      drive(ALU_SUB, 32'd3, 32'd5, 1'b1);
      cyc();
      total++;
      if ({bus.o_valid, bus.o_zero, bus.o_cf, bus.o_of} !== 4'b1010 || bus.o_result !== 32'hFFFF_FFFE) begin
         bad++; $display("FAIL sub_borrow got v/z/c/o=%b res=%h want 1010 res=fffffffe",
                         {bus.o_valid, bus.o_zero, bus.o_cf, bus.o_of}, bus.o_result);
      end
      drive(ALU_SUB, 32'd1, 32'd1, 1'b1);
      cyc();
      bus.i_valid = 1'b0;
      total++;
      if ({bus.o_valid, bus.o_zero, bus.o_cf, bus.o_of} !== 4'b1100 || bus.o_result !== 32'h0) begin
         bad++; $display("FAIL sub_zero got v/z/c/o=%b res=%h want 1100 res=00000000",
                         {bus.o_valid, bus.o_zero, bus.o_cf, bus.o_of}, bus.o_result);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops [8] = '{ALU_AND, ALU_XOR, ALU_SRA, ALU_OR, ALU_SLL,
                               ALU_SRL, ALU_SLL, ALU_SRL};
      logic [31:0] av  [8] = '{32'hF0, 32'hF0, 32'h8000_0000, 32'hF0,
                               32'h8000_0001, 32'h3, 32'h5, 32'h100};
      logic [31:0] bv  [8] = '{32'hAA, 32'hAA, 32'h4, 32'h0F,
                               32'h1, 32'h1, 32'h0, 32'h21};
      logic [31:0] er  [8] = '{32'hA0, 32'h5A, 32'hF800_0000, 32'hFF,
                               32'h2, 32'h1, 32'h5, 32'h80};
      logic        ec  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      bus.i_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(ops[i], av[i], bv[i], 1'b1);
         #1;
         total++;
         if (bus.o_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, bus.o_ready);
         end
         cyc();
         total++;
         if (bus.o_valid !== 1'b1 || bus.o_result !== er[i] || bus.o_cf !== ec[i]) begin
            bad++; $display("FAIL b2b_result[%0d] got v=%b res=%h cf=%b want v=1 res=%h cf=%b",
                            i, bus.o_valid, bus.o_result, bus.o_cf, er[i], ec[i]);
         end
      end
      bus.i_valid = 1'b0;
      cyc();
      total++;
      if (bus.o_valid !== 1'b0) begin
         bad++; $display("FAIL b2b_drain got=%b want=0", bus.o_valid);
      end
   endtask

   // Issue a MUL and count cycles with o_ready low until o_valid appears.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_cf,
                          input logic exp_zero, input string name);
      int n;
      bit rdy_seen;
      bus.i_ready = 1'b1;
      drive(ALU_MUL, a, b, 1'b1);
      cyc();
      bus.i_valid = 1'b0;
      n = 0;
      rdy_seen = 1'b0;
      while (bus.o_valid !== 1'b1 && n < 100) begin
         if (bus.o_ready !== 1'b0) rdy_seen = 1'b1;
         n++;
         cyc();
      end
      total++;
      if (n != 33 || rdy_seen) begin
         bad++; $display("FAIL %s_latency got busy_cycles=%0d ready_seen=%b want 33 and 0",
                         name, n, rdy_seen);
      end
      total++;
      if (bus.o_result !== exp_res || {bus.o_cf, bus.o_zero, bus.o_of} !== {exp_cf, exp_zero, 1'b0}) begin
         bad++; $display("FAIL %s_result got res=%h c/z/o=%b want res=%h c/z/o=%b",
                         name, bus.o_result, {bus.o_cf, bus.o_zero, bus.o_of},
                         exp_res, {exp_cf, exp_zero, 1'b0});
      end
      cyc();
   endtask

   task automatic test_mul();
      run_mul(32'h1_0000, 32'h1_0000, 32'h0, 1'b1, 1'b1, "mul_big");
      run_mul(32'd6, 32'd7, 32'd42, 1'b0, 1'b0, "mul_small");
   endtask

   task automatic test_backpressure();
      bus.i_ready = 1'b0;
      drive(ALU_ADD, 32'd3, 32'd4, 1'b1);
      cyc();
      // Concurrent op waiting for the result slot to free up.
      drive(ALU_XOR, 32'hF0, 32'h0F, 1'b1);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd7 || bus.o_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold[%0d] got v=%b res=%h rdy=%b want v=1 res=00000007 rdy=0",
                            i, bus.o_valid, bus.o_result, bus.o_ready);
         end
         cyc();
      end
      bus.i_ready = 1'b1;
      #1;
      total++;
      if (bus.o_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release_ready got=%b want=1", bus.o_ready);
      end
      cyc();
      bus.i_valid = 1'b0;
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== 32'hFF) begin
         bad++; $display("FAIL bp_next_op got v=%b res=%h want v=1 res=000000ff",
                         bus.o_valid, bus.o_result);
      end
      cyc();
   endtask

   task automatic test_reset_mid_mul();
      int stray;
      bus.i_ready = 1'b1;
      drive(ALU_MUL, 32'd6, 32'd7, 1'b1);
      cyc();                          // accept; first BUSY cycle follows
      bus.i_valid = 1'b0;
      for (int i = 0; i < 9; i++) cyc();   // now in the 10th BUSY cycle
      rst = 1'b1;
      cyc();
      total++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
         bad++; $display("FAIL rst_mul_state got v=%b rdy=%b want v=0 rdy=0",
                         bus.o_valid, bus.o_ready);
      end
      rst = 1'b0;
      #1;
      total++;
      if (bus.o_ready !== 1'b1) begin
         bad++; $display("FAIL rst_mul_ready got=%b want=1", bus.o_ready);
      end
      // The aborted multiply must never surface.
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (bus.o_valid !== 1'b0) stray++;
      end
      total++;
      if (stray != 0) begin
         bad++; $display("FAIL rst_mul_stray got valid_cycles=%0d want 0", stray);
      end
      drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1);
      cyc();
      total++;
      if (bus.o_result !== 32'd1 || bus.o_zero !== 1'b0) begin
         bad++; $display("FAIL slt got res=%h z=%b want res=00000001 z=0", bus.o_result, bus.o_zero);
      end
      drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1);
      cyc();
      total++;
      if (bus.o_result !== 32'd0 || bus.o_zero !== 1'b1) begin
         bad++; $display("FAIL sltu got res=%h z=%b want res=00000000 z=1", bus.o_result, bus.o_zero);
      end
      drive(ALU_ADD, 32'd5, 32'd5, 1'b1);
      cyc();
      drive(4'hF, 32'd5, 32'd5, 1'b1);
      cyc();
      bus.i_valid = 1'b0;
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd0 ||
          {bus.o_zero, bus.o_cf, bus.o_of} !== 3'b100) begin
         bad++; $display("FAIL unknown_op got v=%b res=%h z/c/o=%b want v=1 res=00000000 z/c/o=100",
                         bus.o_valid, bus.o_result, {bus.o_zero, bus.o_cf, bus.o_of});
      end
      cyc();
      total++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
         bad++; $display("FAIL unknown_op_drain got v=%b rdy=%b want v=0 rdy=1",
                         bus.o_valid, bus.o_ready);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_back_to_back();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
